// File: rtl/time_keeper.sv
// Thermostat real-time clock: day-of-week, hour and minute kept from the
// system clock. Set mode freezes time and lets the three buttons step the
// fields, with press-and-hold auto-repeat. All outputs are registers.
module time_keeper #(
    parameter int g_clk_freq = 20000,
    parameter int g_btn_init = 20000,
    parameter int g_btn_hold = 5000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_set_time_n,
    input  logic       i_incr_day_n,
    input  logic       i_incr_hr_n,
    input  logic       i_incr_min_n,
    output logic [6:0] o_day,
    output logic [4:0] o_hour,
    output logic [5:0] o_minute
);

    localparam int TW = (g_clk_freq > 1) ? $clog2(g_clk_freq) : 1;
    localparam int HW = (g_btn_init > 0) ? $clog2(g_btn_init + 1) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(g_clk_freq - 1);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(g_btn_init);
    // Reloading the counter this far below the fire point makes the next
    // repeat land exactly g_btn_hold cycles later.
    localparam logic [HW-1:0] HOLD_REARM = HW'(g_btn_init - g_btn_hold);

    // bit 0 = set_time, 1 = day, 2 = hour, 3 = minute (all active-low levels)
    logic [3:0] sync_1;
    logic [3:0] sync_2;
    logic [3:0] sync_prev;

    logic [TW-1:0] tick;
    logic [5:0]    sec;

    // button index 0 = day, 1 = hour, 2 = minute
    logic [2:0][HW-1:0] hold_cnt;
    logic [2:0][HW-1:0] hold_nxt;
    logic [2:0]         armed;
    logic [2:0]         armed_nxt;
    logic [2:0]         btn_step;

    logic       set_mode;
    logic       day_onehot;
    logic [6:0] day_inc;
    logic [4:0] hour_inc;
    logic [5:0] minute_inc;

    assign set_mode   = ~sync_2[0];
    assign day_onehot = (o_day != 7'd0) && ((o_day & (o_day - 7'd1)) == 7'd0);
    // A corrupted day vector recovers to Sunday on its next step.
    assign day_inc    = day_onehot ? {o_day[5:0], o_day[6]} : 7'b0000001;
    assign hour_inc   = (o_hour >= 5'd23) ? 5'd0 : o_hour + 5'd1;
    assign minute_inc = (o_minute >= 6'd59) ? 6'd0 : o_minute + 6'd1;

    // Two-flop synchronizer plus one extra stage for press-edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_1    <= 4'hF;
            sync_2    <= 4'hF;
            sync_prev <= 4'hF;
        end else begin
            sync_1    <= {i_incr_min_n, i_incr_hr_n, i_incr_day_n, i_set_time_n};
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    // Per-button press/hold decode; auto-repeat only after a press seen in set mode
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            btn_step[i]  = 1'b0;
            hold_nxt[i]  = '0;
            armed_nxt[i] = 1'b0;
            if (set_mode && !sync_2[i+1]) begin
                if (sync_prev[i+1]) begin
                    btn_step[i]  = 1'b1;
                    armed_nxt[i] = 1'b1;
                end else if (armed[i]) begin
                    armed_nxt[i] = 1'b1;
                    if (hold_cnt[i] + 1'b1 == HOLD_FIRE) begin
                        btn_step[i] = 1'b1;
                        hold_nxt[i] = HOLD_REARM;
                    end else begin
                        hold_nxt[i] = hold_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Hold counters and arm flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hold_cnt <= '0;
            armed    <= '0;
        end else begin
            hold_cnt <= hold_nxt;
            armed    <= armed_nxt;
        end
    end

    // Timekeeping: carries in run mode, independent non-carrying steps in set mode
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick     <= '0;
            sec      <= '0;
            o_minute <= '0;
            o_hour   <= '0;
            o_day    <= 7'b0000001;
        end else if (!set_mode) begin
            if (tick == TICK_MAX) begin
                tick <= '0;
                if (sec >= 6'd59) begin
                    sec      <= '0;
                    o_minute <= minute_inc;
                    if (o_minute >= 6'd59) begin
                        o_hour <= hour_inc;
                        if (o_hour >= 5'd23) begin
                            o_day <= day_inc;
                        end
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end else begin
                tick <= tick + 1'b1;
            end
        end else begin
            tick <= '0;
            sec  <= '0;
            if (btn_step[0]) o_day    <= day_inc;
            if (btn_step[1]) o_hour   <= hour_inc;
            if (btn_step[2]) o_minute <= minute_inc;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed table, hand-written corner sequences and a
// randomized phase, all compared cycle by cycle against a seconds-of-week model.
module tb_time_keeper;

    localparam int FREQ = 5;
    localparam int INIT = 5;
    localparam int HOLD = 1;
    localparam int WEEK = 7 * 24 * 3600;

    logic       r_clk;
    logic       reset;
    logic       set_n, day_n, hr_n, min_n;
    logic [6:0] o_day;
    logic [4:0] o_hour;
    logic [5:0] o_minute;

    int n_pass;
    int n_total;

    time_keeper #(.g_clk_freq(FREQ), .g_btn_init(INIT), .g_btn_hold(HOLD)) dut (
        .i_clk        (r_clk),
        .i_reset      (reset),
        .i_set_time_n (set_n),
        .i_incr_day_n (day_n),
        .i_incr_hr_n  (hr_n),
        .i_incr_min_n (min_n),
        .o_day        (o_day),
        .o_hour       (o_hour),
        .o_minute     (o_minute)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // ---------------- reference model ----------------
    int m_day, m_hr, m_min, m_sec, m_tick;
    int md1[4], ms[4], mp[4], mk[4], marm[4];

    task automatic model_step();
        int inp[4];
        int sow;
        bit stp;
        inp[0] = int'(set_n); inp[1] = int'(day_n); inp[2] = int'(hr_n); inp[3] = int'(min_n);
        if (reset) begin
            m_day = 0; m_hr = 0; m_min = 0; m_sec = 0; m_tick = 0;
            for (int b = 0; b < 4; b++) begin
                md1[b] = 1; ms[b] = 1; mp[b] = 1; mk[b] = 0; marm[b] = 0;
            end
            return;
        end
        if (ms[0] == 1) begin
            for (int b = 1; b < 4; b++) begin marm[b] = 0; mk[b] = 0; end
            m_tick++;
            if (m_tick == FREQ) begin
                m_tick = 0;
                sow = ((m_day * 24 + m_hr) * 60 + m_min) * 60 + m_sec + 1;
                if (sow == WEEK) sow = 0;
                m_day = sow / 86400;
                m_hr  = (sow / 3600) % 24;
                m_min = (sow / 60) % 60;
                m_sec = sow % 60;
            end
        end else begin
            m_tick = 0;
            m_sec  = 0;
            for (int b = 1; b < 4; b++) begin
                stp = 0;
                if (ms[b] == 0) begin
                    if (mp[b] == 1) begin
                        stp = 1; mk[b] = 0; marm[b] = 1;
                    end else if (marm[b] == 1) begin
                        mk[b]++;
                        if (mk[b] >= INIT && (mk[b] - INIT) % HOLD == 0) stp = 1;
                    end
                end else begin
                    marm[b] = 0; mk[b] = 0;
                end
                if (stp) begin
                    if (b == 1) m_day = (m_day + 1) % 7;
                    if (b == 2) m_hr  = (m_hr + 1) % 24;
                    if (b == 3) m_min = (m_min + 1) % 60;
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            mp[b] = ms[b]; ms[b] = md1[b]; md1[b] = inp[b];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle();
        logic [6:0] eday;
        @(posedge r_clk);
        model_step();
        @(negedge r_clk);
        eday = 7'(1 << m_day);
        chk("model_day", 32'(o_day), 32'(eday));
        chk("model_hour", 32'(o_hour), 32'(m_hr));
        chk("model_min", 32'(o_minute), 32'(m_min));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       rst;
        logic       set_n;
        logic       day_n;
        logic       hr_n;
        logic       min_n;
        int         n;
        logic [6:0] e_day;
        logic [4:0] e_hr;
        logic [5:0] e_min;
    } vec_t;

    vec_t tbl[27];
    int   frozen_min;

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; set_n = 1'b1; day_n = 1'b1; hr_n = 1'b1; min_n = 1'b1;

        //            rst   set   day   hr    min    n    day      hr     min
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,   2, 7'h01, 5'd0,  6'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 300, 7'h01, 5'd0,  6'd1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 300, 7'h01, 5'd0,  6'd2};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   3, 7'h01, 5'd0,  6'd2};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  61, 7'h01, 5'd0,  6'd57};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h01, 5'd0,  6'd59};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  27, 7'h01, 5'd21, 6'd59};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h01, 5'd23, 6'd59};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  10, 7'h10, 5'd23, 6'd59};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h40, 5'd23, 6'd59};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 301, 7'h40, 5'd23, 6'd59};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,   1, 7'h01, 5'd0,  6'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   3, 7'h01, 5'd0,  6'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  27, 7'h01, 5'd21, 6'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h01, 5'd23, 6'd0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,   2, 7'h01, 5'd23, 6'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h01, 5'd0,  6'd0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  10, 7'h10, 5'd0,  6'd0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h40, 5'd0,  6'd0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,   2, 7'h40, 5'd0,  6'd0};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h01, 5'd0,  6'd0};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  63, 7'h01, 5'd0,  6'd57};
        tbl[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h01, 5'd0,  6'd59};
        tbl[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,   2, 7'h01, 5'd0,  6'd59};
        tbl[24] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h01, 5'd0,  6'd0};
        tbl[25] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  20, 7'h01, 5'd0,  6'd14};
        tbl[26] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,   4, 7'h01, 5'd0,  6'd16};

        @(negedge r_clk);
        for (int r = 0; r < 27; r++) begin
            reset = tbl[r].rst;  set_n = tbl[r].set_n;
            day_n = tbl[r].day_n; hr_n = tbl[r].hr_n; min_n = tbl[r].min_n;
            run(tbl[r].n);
            chk($sformatf("row%0d_day", r), 32'(o_day), 32'(tbl[r].e_day));
            chk($sformatf("row%0d_hour", r), 32'(o_hour), 32'(tbl[r].e_hr));
            chk($sformatf("row%0d_min", r), 32'(o_minute), 32'(tbl[r].e_min));
        end

        // Minute held across exit from set mode, then re-entry while still held
        min_n = 1'b0;
        run(10);
        set_n = 1'b1;
        run(320);
        set_n = 1'b0;
        run(3);
        frozen_min = m_min;
        run(30);
        chk("reentry_held_no_step", 32'(o_minute), 32'(frozen_min));
        min_n = 1'b1;
        run(4);
        min_n = 1'b0;
        run(4);
        chk("repress_single_step", 32'(o_minute), 32'((frozen_min + 1) % 60));
        min_n = 1'b1;
        run(4);

        // Reset in the middle of an auto-repeat hold
        hr_n = 1'b0;
        run(12);
        reset = 1'b1;
        run(1);
        chk("midhold_reset_day", 32'(o_day), 32'h01);
        chk("midhold_reset_hour", 32'(o_hour), 32'd0);
        chk("midhold_reset_min", 32'(o_minute), 32'd0);
        reset = 1'b0;
        hr_n = 1'b1;
        run(6);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) set_n = ~set_n;
            if ($urandom_range(0, 11) == 0) day_n = ~day_n;
            if ($urandom_range(0, 11) == 0) hr_n = ~hr_n;
            if ($urandom_range(0, 9) == 0) min_n = ~min_n;
            reset = ($urandom_range(0, 1499) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
